// File: rtl/cla_pipe_pkg.sv
// Shared widths and the per-group stage-1 record
// for the pipelined carry-lookahead adder.
package cla_pipe_pkg;

  localparam int GROUP_W    = 3;
  localparam int NUM_GROUPS = 4;
  localparam int WIDTH      = GROUP_W * NUM_GROUPS;

  typedef struct packed {
    logic               p;
    logic               g;
    logic [GROUP_W-1:0] sum0;
    logic [GROUP_W-1:0] sum1;
  } grp_t;

endpackage

// File: rtl/group_precompute.sv
// One lookahead group: group propagate/generate plus
// both conditional sums, purely combinational.
module group_precompute
  import cla_pipe_pkg::*;
#(
  parameter int W = GROUP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         p,
  output logic         g,
  output logic [W-1:0] sum0,
  output logic [W-1:0] sum1
);

  logic [W-1:0] bit_p;
  logic [W-1:0] bit_g;

  assign bit_p = a | b;
  assign bit_g = a & b;
  assign p     = &bit_p;

  always_comb begin
    g = bit_g[0];
    for (int i = 1; i < W; i++) begin
      g = bit_g[i] | (bit_p[i] & g);
    end
  end

  assign sum0 = a + b;
  assign sum1 = a + b + W'(1);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage carry-select/lookahead adder with
// valid/ready handshakes on both sides.
module cla_pipe_adder #(
  parameter  int GROUP_W    = cla_pipe_pkg::GROUP_W,
  parameter  int NUM_GROUPS = cla_pipe_pkg::NUM_GROUPS,
  localparam int WIDTH      = GROUP_W * NUM_GROUPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_c_in,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_s,
  output logic             io_c_out,
  output logic             io_pg,
  output logic             io_gg
);

  logic [NUM_GROUPS-1:0]              pre_p;
  logic [NUM_GROUPS-1:0]              pre_g;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] pre_sum0;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] pre_sum1;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
    group_precompute #(
      .W(GROUP_W)
    ) u_grp (
      .a   (io_a[k*GROUP_W +: GROUP_W]),
      .b   (io_b[k*GROUP_W +: GROUP_W]),
      .p   (pre_p[k]),
      .g   (pre_g[k]),
      .sum0(pre_sum0[k]),
      .sum1(pre_sum1[k])
    );
  end

  logic                               s1_valid;
  logic [NUM_GROUPS-1:0]              s1_p;
  logic [NUM_GROUPS-1:0]              s1_g;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] s1_sum0;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] s1_sum1;
  logic                               s1_cin;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_s;
  logic             s2_cout;
  logic             s2_pg;
  logic             s2_gg;

  logic s2_load;
  logic in_fire;

  assign s2_load     = !s2_valid || io_out_ready;
  assign io_in_ready = !reset && (!s1_valid || s2_load);
  assign in_fire     = io_in_valid && io_in_ready;

  // cz is the same chain with carry-in forced low (block generate)
  logic [NUM_GROUPS:0]                c;
  logic [NUM_GROUPS:0]                cz;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] nxt_s;

  always_comb begin
    c     = '0;
    cz    = '0;
    nxt_s = '0;
    c[0]  = s1_cin;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      c[k+1]   = s1_g[k] | (s1_p[k] & c[k]);
      cz[k+1]  = s1_g[k] | (s1_p[k] & cz[k]);
      nxt_s[k] = c[k] ? s1_sum1[k] : s1_sum0[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_cin   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_p     <= pre_p;
      s1_g     <= pre_g;
      s1_sum0  <= pre_sum0;
      s1_sum1  <= pre_sum1;
      s1_cin   <= io_c_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_cout  <= 1'b0;
      s2_pg    <= 1'b0;
      s2_gg    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_s    <= nxt_s;
        s2_cout <= c[NUM_GROUPS];
        s2_pg   <= &s1_p;
        s2_gg   <= cz[NUM_GROUPS];
      end
    end
  end

  assign io_out_valid = !reset && s2_valid;
  assign io_s         = reset ? '0 : s2_s;
  assign io_c_out     = !reset && s2_cout;
  assign io_pg        = !reset && s2_pg;
  assign io_gg        = !reset && s2_gg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks for the
// pipelined carry-lookahead adder.
module tb_cla_pipe_adder;

  localparam int WIDTH = 12;
  localparam int NBEAT = 10000;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_c_in;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_s;
  logic             io_c_out;
  logic             io_pg;
  logic             io_gg;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cla_pipe_adder dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_a        (io_a),
    .io_b        (io_b),
    .io_c_in     (io_c_in),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_s        (io_s),
    .io_c_out    (io_c_out),
    .io_pg       (io_pg),
    .io_gg       (io_gg)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic ci);
    io_in_valid = v;
    io_a        = a;
    io_b        = b;
    io_c_in     = ci;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    io_out_ready = 1'b1;
    #1;
    checks++;
    if ({io_out_valid, io_s, io_c_out, io_pg, io_gg, io_in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b pg=%b gg=%b rdy=%b, need all 0",
               io_out_valid, io_s, io_c_out, io_pg, io_gg, io_in_ready);
    end
    tick();
    tick();
    checks++;
    if ({io_out_valid, io_s, io_in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_held: got v=%b s=%h rdy=%b, need 0", io_out_valid, io_s, io_in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b, need rdy=1 v=0", io_in_ready, io_out_valid);
    end
  endtask

  task automatic test_carry_chain();
    io_out_ready = 1'b1;
    drive(1'b1, 12'hFFF, 12'h001, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL chain_latency: got out_valid=%b after 1 cycle, need 0", io_out_valid);
    end
    tick();
    checks++;
    if ({io_out_valid, io_s, io_c_out, io_pg, io_gg} !== {1'b1, 12'h000, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL chain_result: got v=%b s=%h c=%b pg=%b gg=%b, need v=1 s=000 c=1 pg=1 gg=1",
               io_out_valid, io_s, io_c_out, io_pg, io_gg);
    end
    tick();
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL chain_bubble: got out_valid=%b, need 0", io_out_valid);
    end
  endtask

  task automatic test_alternating();
    io_out_ready = 1'b1;
    drive(1'b1, 12'h555, 12'h2AA, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if ({io_out_valid, io_s, io_c_out, io_pg, io_gg} !== {1'b1, 12'h800, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alt_result: got v=%b s=%h c=%b pg=%b gg=%b, need v=1 s=800 c=0 pg=0 gg=0",
               io_out_valid, io_s, io_c_out, io_pg, io_gg);
    end
    tick();
  endtask

  task automatic test_backpressure();
    io_out_ready = 1'b0;
    drive(1'b1, 12'd1, 12'd1, 1'b0);
    tick();
    drive(1'b1, 12'd2, 12'd2, 1'b0);
    tick();
    drive(1'b1, 12'd3, 12'd3, 1'b0);
    #1;
    checks++;
    if (io_in_ready !== 1'b0 || io_out_valid !== 1'b1 || io_s !== 12'h002) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b s=%h, need rdy=0 v=1 s=002",
               io_in_ready, io_out_valid, io_s);
    end
    tick();
    checks++;
    if (io_in_ready !== 1'b0 || io_s !== 12'h002) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b s=%h, need rdy=0 s=002", io_in_ready, io_s);
    end
    io_out_ready = 1'b1;
    #1;
    checks++;
    if (io_in_ready !== 1'b1 || io_s !== 12'h002 || io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b s=%h, need rdy=1 v=1 s=002",
               io_in_ready, io_out_valid, io_s);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (io_out_valid !== 1'b1 || io_s !== 12'h004) begin
      errors++;
      $display("FAIL bp_second: got v=%b s=%h, need v=1 s=004", io_out_valid, io_s);
    end
    tick();
    checks++;
    if (io_out_valid !== 1'b1 || io_s !== 12'h006) begin
      errors++;
      $display("FAIL bp_third: got v=%b s=%h, need v=1 s=006", io_out_valid, io_s);
    end
    tick();
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b, need 0", io_out_valid);
    end
  endtask

  task automatic test_reset_flight();
    int seen;
    io_out_ready = 1'b0;
    drive(1'b1, 12'd5, 12'd5, 1'b0);
    tick();
    drive(1'b1, 12'd7, 12'd7, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({io_out_valid, io_s, io_c_out, io_pg, io_gg, io_in_ready} !== '0) begin
      errors++;
      $display("FAIL flight_reset_cycle: got v=%b s=%h c=%b pg=%b gg=%b rdy=%b, need all 0",
               io_out_valid, io_s, io_c_out, io_pg, io_gg, io_in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (io_out_valid !== 1'b0 || io_s !== 12'h000 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flight_after: got v=%b s=%h rdy=%b, need v=0 s=000 rdy=1",
               io_out_valid, io_s, io_in_ready);
    end
    io_out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (io_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flight_stale: got %0d stale outputs, need 0", seen);
    end
  endtask

  task automatic test_random();
    logic [WIDTH:0] q[$];
    logic [WIDTH:0] exp;
    logic [WIDTH+2:0] held;
    logic held_valid;
    int sent, got, cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    held = '0;
    held_valid = 1'b0;
    while (got < NBEAT && cyc < 80000) begin
      io_in_valid  = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
      io_a         = WIDTH'($urandom);
      io_b         = WIDTH'($urandom);
      io_c_in      = 1'($urandom);
      io_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held_valid) begin
        checks++;
        if ({io_c_out, io_s, io_pg, io_gg} !== held) begin
          errors++;
          $display("FAIL rand_stall_hold: got %h, need %h", {io_c_out, io_s, io_pg, io_gg}, held);
        end
      end
      held_valid = io_out_valid && !io_out_ready;
      held = {io_c_out, io_s, io_pg, io_gg};
      if (io_out_valid && io_out_ready) begin
        checks++;
        got++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: output %h with nothing outstanding", {io_c_out, io_s});
        end else begin
          exp = q.pop_front();
          if ({io_c_out, io_s} !== exp) begin
            errors++;
            $display("FAIL rand_sum: beat %0d got %h, need %h", got, {io_c_out, io_s}, exp);
          end
        end
      end
      if (io_in_valid && io_in_ready) begin
        q.push_back({1'b0, io_a} + {1'b0, io_b} + (WIDTH+1)'(io_c_in));
        sent++;
      end
      tick();
      cyc++;
    end
    io_in_valid = 1'b0;
    checks++;
    if (sent != NBEAT || got != NBEAT || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: sent=%0d got=%0d left=%0d, need %0d/%0d/0",
               sent, got, q.size(), NBEAT, NBEAT);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_alternating();
    test_backpressure();
    test_reset_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
